// File: rtl/kyber_encrypt_core.sv
// Baby-Kyber encryption engine: u = A^T*r + e1, v = t^T*r + e2 + Decompress(m)
// over Z_Q[x]/(x^N+1), using one time-shared, two-stage modular MAC.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   job request handshake (in_ready high only when idle)
//   abort               synchronous cancel of a running job
//   message             message bits, bit c adds (Q+1)/2 to v coeff c
//   a_flat              A[i][j] coeff c at bit ((i*K+j)*N+c)*W, unsigned
//   t_flat              t[j] coeff c at bit (j*N+c)*W, unsigned
//   noise_flat          r[0..K-1], e1[0..K-1], e2; signed coefficients
//   out_valid/out_ready ciphertext handshake, outputs held until accepted
//   u_flat, v_flat      ciphertext coefficients in [0,Q-1]
//   err                 some noise coefficient lay outside [-ETA,ETA]
module kyber_encrypt_core #(
    parameter int K   = 2,
    parameter int N   = 4,
    parameter int Q   = 17,
    parameter int ETA = 1,
    parameter int W   = 32,
    localparam int QW = $clog2(Q)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     abort,
    input  logic [N-1:0]             message,
    input  logic [K*K*N*W-1:0]       a_flat,
    input  logic [K*N*W-1:0]         t_flat,
    input  logic [(2*K+1)*N*W-1:0]   noise_flat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [K*N*QW-1:0]        u_flat,
    output logic [N*QW-1:0]          v_flat,
    output logic                     err
);

    localparam int KB = (K > 1) ? $clog2(K) : 1;
    localparam int NB = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * QW;
    localparam int AW = 2 * QW + 1;

    // Offset added before subtracting a product keeps the operand
    // non-negative: every product is below Q*(Q-1).
    localparam logic [AW-1:0] QQ   = AW'(Q * (Q - 1));
    localparam logic [AW-1:0] QA   = AW'(Q);
    localparam logic [QW:0]   QU   = (QW + 1)'(Q);
    localparam logic [QW+1:0] QV   = (QW + 2)'(Q);
    localparam logic [QW+1:0] HALF = (QW + 2)'((Q + 1) / 2);
    localparam logic signed [W:0] ETA_S = (W + 1)'(ETA);
    localparam logic signed [W:0] Q_S   = (W + 1)'(Q);

    typedef enum logic [2:0] {
        IDLE,
        MUL_U,
        MUL_V,
        FINAL,
        DONE
    } state_t;

    state_t state, nxt;

    logic [QW-1:0] a_q  [K][K][N];
    logic [QW-1:0] t_q  [K][N];
    logic [QW-1:0] r_q  [K][N];
    logic [QW-1:0] e1_q [K][N];
    logic [QW-1:0] e2_q [N];
    logic [N-1:0]  msg_q;

    logic [QW-1:0] u_acc [K][N];
    logic [QW-1:0] v_acc [N];

    logic [KB-1:0] ci, cj;
    logic [NB-1:0] cm, cn;
    logic          vdone;

    // MAC pipeline register between multiply and accumulate
    logic          p_v;
    logic          p_sub;
    logic          p_isv;
    logic [KB-1:0] p_row;
    logic [NB-1:0] p_idx;
    logic [PW-1:0] p_prod;

    logic accept;
    logic issue;
    logic noise_bad;
    logic i_max, j_max, m_max, n_max;
    logic last_u, last_v;

    logic [QW-1:0] op_a, op_b;
    logic [NB:0]   idx_sum;
    logic          wrap;
    logic [NB-1:0] idx;
    logic [QW-1:0] old;
    logic [AW-1:0] opnd;
    logic [QW-1:0] mac;

    logic [K*N*QW-1:0] u_nxt;
    logic [N*QW-1:0]   v_nxt;

    function automatic logic [QW-1:0] red_u(input logic [W-1:0] x);
        return QW'(x % W'(Q));
    endfunction

    function automatic logic [QW-1:0] red_s(input logic [W-1:0] x);
        logic signed [W:0] xs;
        logic signed [W:0] r;
        xs = $signed({x[W-1], x});
        r  = xs % Q_S;
        if (r < 0) r = r + Q_S;
        return QW'(r);
    endfunction

    function automatic logic bad_s(input logic [W-1:0] x);
        logic signed [W:0] xs;
        xs = $signed({x[W-1], x});
        return (xs > ETA_S) || (xs < -ETA_S);
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (in_valid && !abort) nxt = MUL_U;
            MUL_U:   if (abort) nxt = IDLE;
                     else if (last_u) nxt = MUL_V;
            MUL_V:   if (abort) nxt = IDLE;
                     else if (vdone) nxt = FINAL;
            FINAL:   nxt = abort ? IDLE : DONE;
            DONE:    if (abort || out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        accept    = (state == IDLE) && in_valid && !abort;
        // MUL_V spends one extra cycle draining the MAC pipeline
        issue     = (state == MUL_U) || ((state == MUL_V) && !vdone);
    end

    // ---------------- loop counters ----------------
    always_comb begin
        i_max  = (ci == KB'(K - 1));
        j_max  = (cj == KB'(K - 1));
        m_max  = (cm == NB'(N - 1));
        n_max  = (cn == NB'(N - 1));
        last_u = i_max && j_max && m_max && n_max;
        last_v = j_max && m_max && n_max;
    end

    always_comb begin
        noise_bad = 1'b0;
        for (int k = 0; k < (2 * K + 1) * N; k++)
            noise_bad = noise_bad | bad_s(noise_flat[k*W +: W]);
    end

    // ---------------- MAC stage 1: multiply ----------------
    always_comb begin
        op_a    = (state == MUL_U) ? a_q[cj][ci][cm] : t_q[cj][cm];
        op_b    = r_q[cj][cn];
        idx_sum = {1'b0, cm} + {1'b0, cn};
        // x^(m+n) with m+n >= N folds back as -x^(m+n-N)
        wrap    = (idx_sum >= (NB + 1)'(N));
        idx     = NB'(wrap ? idx_sum - (NB + 1)'(N) : idx_sum);
    end

    // ---------------- MAC stage 2: accumulate ----------------
    always_comb begin
        old  = p_isv ? v_acc[p_idx] : u_acc[p_row][p_idx];
        opnd = p_sub ? AW'(old) + QQ - AW'(p_prod)
                     : AW'(old) + AW'(p_prod);
        mac  = QW'(opnd % QA);
    end

    // ---------------- final combine ----------------
    always_comb begin
        u_nxt = '0;
        v_nxt = '0;
        for (int i = 0; i < K; i++)
            for (int c = 0; c < N; c++)
                u_nxt[(i*N+c)*QW +: QW] =
                    QW'(({1'b0, u_acc[i][c]} + {1'b0, e1_q[i][c]}) % QU);
        for (int c = 0; c < N; c++)
            v_nxt[c*QW +: QW] =
                QW'(({2'b0, v_acc[c]} + {2'b0, e2_q[c]}
                     + (msg_q[c] ? HALF : '0)) % QV);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < K; i++)
                for (int c = 0; c < N; c++) begin
                    for (int j = 0; j < K; j++) a_q[i][j][c] <= '0;
                    t_q[i][c]   <= '0;
                    r_q[i][c]   <= '0;
                    e1_q[i][c]  <= '0;
                    u_acc[i][c] <= '0;
                end
            for (int c = 0; c < N; c++) begin
                e2_q[c]  <= '0;
                v_acc[c] <= '0;
            end
            msg_q  <= '0;
            ci     <= '0;
            cj     <= '0;
            cm     <= '0;
            cn     <= '0;
            vdone  <= 1'b0;
            p_v    <= 1'b0;
            p_sub  <= 1'b0;
            p_isv  <= 1'b0;
            p_row  <= '0;
            p_idx  <= '0;
            p_prod <= '0;
            u_flat <= '0;
            v_flat <= '0;
            err    <= 1'b0;
        end else if (abort && state != IDLE) begin
            for (int i = 0; i < K; i++)
                for (int c = 0; c < N; c++) u_acc[i][c] <= '0;
            for (int c = 0; c < N; c++) v_acc[c] <= '0;
            ci    <= '0;
            cj    <= '0;
            cm    <= '0;
            cn    <= '0;
            vdone <= 1'b0;
            p_v   <= 1'b0;
        end else begin
            if (accept) begin
                for (int i = 0; i < K; i++)
                    for (int c = 0; c < N; c++) begin
                        for (int j = 0; j < K; j++)
                            a_q[i][j][c] <= red_u(a_flat[((i*K+j)*N+c)*W +: W]);
                        t_q[i][c]   <= red_u(t_flat[(i*N+c)*W +: W]);
                        r_q[i][c]   <= red_s(noise_flat[(i*N+c)*W +: W]);
                        e1_q[i][c]  <= red_s(noise_flat[((K+i)*N+c)*W +: W]);
                        u_acc[i][c] <= '0;
                    end
                for (int c = 0; c < N; c++) begin
                    e2_q[c]  <= red_s(noise_flat[(2*K*N+c)*W +: W]);
                    v_acc[c] <= '0;
                end
                msg_q <= message;
                err   <= noise_bad;
                ci    <= '0;
                cj    <= '0;
                cm    <= '0;
                cn    <= '0;
            end

            if (issue) begin
                p_prod <= PW'(op_a) * PW'(op_b);
                p_sub  <= wrap;
                p_idx  <= idx;
                p_row  <= ci;
                p_isv  <= (state == MUL_V);
                if (!n_max) cn <= cn + NB'(1);
                else begin
                    cn <= '0;
                    if (!m_max) cm <= cm + NB'(1);
                    else begin
                        cm <= '0;
                        if (!j_max) cj <= cj + KB'(1);
                        else begin
                            cj <= '0;
                            if (state == MUL_U)
                                ci <= i_max ? '0 : ci + KB'(1);
                        end
                    end
                end
            end
            p_v <= issue;

            if (p_v) begin
                if (p_isv) v_acc[p_idx] <= mac;
                else       u_acc[p_row][p_idx] <= mac;
            end

            vdone <= (state == MUL_V) && (vdone || (issue && last_v));

            if (state == FINAL) begin
                u_flat <= u_nxt;
                v_flat <= v_nxt;
            end
        end
    end

endmodule

// File: tb/tb_kyber_encrypt_core.sv
// Bench for kyber_encrypt_core: polynomial-level golden model, directed
// and random jobs, backpressure, abort and mid-job reset.
module tb_kyber_encrypt_core;

    localparam int K   = 2;
    localparam int N   = 4;
    localparam int Q   = 17;
    localparam int ETA = 1;
    localparam int W   = 32;
    localparam int QW  = 5;
    localparam int LAT = (K + 1) * K * N * N + 2;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic in_ready;
    logic abort;
    logic [N-1:0] message;
    logic [K*K*N*W-1:0] a_flat;
    logic [K*N*W-1:0] t_flat;
    logic [(2*K+1)*N*W-1:0] noise_flat;
    logic out_valid;
    logic out_ready;
    logic [K*N*QW-1:0] u_flat;
    logic [N*QW-1:0] v_flat;
    logic err;

    always #5 clk = ~clk;

    kyber_encrypt_core #(
        .K(K), .N(N), .Q(Q), .ETA(ETA), .W(W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .abort(abort),
        .message(message),
        .a_flat(a_flat),
        .t_flat(t_flat),
        .noise_flat(noise_flat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .u_flat(u_flat),
        .v_flat(v_flat),
        .err(err)
    );

    int checks = 0;
    int errors = 0;

    bit [31:0] A [K][K][N];
    bit [31:0] T [K][N];
    int R  [K][N];
    int E1 [K][N];
    int E2 [N];

    logic [K*N*QW-1:0] exp_u;
    logic [N*QW-1:0]   exp_v;
    logic              exp_err;
    logic [K*N*QW-1:0] prev_u;
    bit ov_ok = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int md(input longint x);
        return int'(((x % Q) + Q) % Q);
    endfunction

    function automatic logic [N*QW-1:0] pack_v(input int c0, input int c1,
                                               input int c2, input int c3);
        logic [N*QW-1:0] p;
        p = '0;
        p[0*QW +: QW] = QW'(c0);
        p[1*QW +: QW] = QW'(c1);
        p[2*QW +: QW] = QW'(c2);
        p[3*QW +: QW] = QW'(c3);
        return p;
    endfunction

    // Schoolbook negacyclic products evaluated in plain integers,
    // reduced once at the very end.
    task automatic model();
        longint uu [K][N];
        longint vv [N];
        int d, s;
        exp_err = 1'b0;
        for (int i = 0; i < K; i++)
            for (int c = 0; c < N; c++) uu[i][c] = E1[i][c];
        for (int c = 0; c < N; c++)
            vv[c] = E2[c] + (message[c] ? (Q + 1) / 2 : 0);
        for (int j = 0; j < K; j++)
            for (int m = 0; m < N; m++)
                for (int n = 0; n < N; n++) begin
                    d = (m + n) % N;
                    s = (m + n >= N) ? -1 : 1;
                    for (int i = 0; i < K; i++)
                        uu[i][d] += s * md(longint'(A[j][i][m])) * md(R[j][n]);
                    vv[d] += s * md(longint'(T[j][m])) * md(R[j][n]);
                end
        for (int i = 0; i < K; i++)
            for (int c = 0; c < N; c++) begin
                exp_u[(i*N+c)*QW +: QW] = QW'(md(uu[i][c]));
                if (R[i][c] > ETA || R[i][c] < -ETA) exp_err = 1'b1;
                if (E1[i][c] > ETA || E1[i][c] < -ETA) exp_err = 1'b1;
            end
        for (int c = 0; c < N; c++) begin
            exp_v[c*QW +: QW] = QW'(md(vv[c]));
            if (E2[c] > ETA || E2[c] < -ETA) exp_err = 1'b1;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < K; i++)
            for (int c = 0; c < N; c++) begin
                for (int j = 0; j < K; j++)
                    a_flat[((i*K+j)*N+c)*W +: W] = A[i][j][c];
                t_flat[(i*N+c)*W +: W] = T[i][c];
                noise_flat[(i*N+c)*W +: W] = R[i][c];
                noise_flat[((K+i)*N+c)*W +: W] = E1[i][c];
            end
        for (int c = 0; c < N; c++)
            noise_flat[(2*K*N+c)*W +: W] = E2[c];
    endtask

    task automatic clear_all();
        for (int i = 0; i < K; i++)
            for (int c = 0; c < N; c++) begin
                for (int j = 0; j < K; j++) A[i][j][c] = 0;
                T[i][c]  = 0;
                R[i][c]  = 0;
                E1[i][c] = 0;
            end
        for (int c = 0; c < N; c++) E2[c] = 0;
        message = '0;
    endtask

    task automatic randomize_job(input bit wide);
        for (int i = 0; i < K; i++)
            for (int c = 0; c < N; c++) begin
                for (int j = 0; j < K; j++)
                    A[i][j][c] = wide ? $urandom : $urandom_range(0, Q - 1);
                T[i][c]  = wide ? $urandom : $urandom_range(0, Q - 1);
                R[i][c]  = int'($urandom_range(0, 2)) - 1;
                E1[i][c] = int'($urandom_range(0, 2)) - 1;
            end
        for (int c = 0; c < N; c++) E2[c] = int'($urandom_range(0, 2)) - 1;
        message = N'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_job(input int hold);
        int lat;
        bit busy;
        model();
        drive();
        wait_idle();
        in_valid = 1'b1;
        ov_ok = 1'b1;
        @(negedge clk);
        lat = 0;
        busy = 1'b0;
        while (!out_valid && lat < 300) begin
            if (in_ready) busy = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(LAT));
        chk("busy_in_ready", 64'(busy), 64'd0);
        in_valid = 1'b0;
        if (hold > 0) begin
            out_ready = 1'b0;
            repeat (hold) begin
                @(negedge clk);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                chk("bp_out_valid", 64'(out_valid), 64'd1);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk("ret_in_ready", 64'(in_ready), 64'd1);
        chk("ret_out_valid", 64'(out_valid), 64'd0);
        ov_ok = 1'b0;
    endtask

    // Every cycle a ciphertext is offered, it must match the model.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!ov_ok) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid actual=1 required=0");
            end else begin
                chk("u_flat", 64'(u_flat), 64'(exp_u));
                chk("v_flat", 64'(v_flat), 64'(exp_v));
                chk("err", 64'(err), 64'(exp_err));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        abort = 1'b0;
        out_ready = 1'b1;
        message = '0;
        a_flat = '0;
        t_flat = '0;
        noise_flat = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_u", 64'(u_flat), 64'd0);
        chk("rst_v", 64'(v_flat), 64'd0);

        // zero operands, message only
        clear_all();
        message = 4'b1011;
        model();
        chk("pin_t1_u", 64'(exp_u), 64'd0);
        chk("pin_t1_v", 64'(exp_v), 64'(pack_v(9, 9, 0, 9)));
        run_job(0);

        // x^3 * x wraps to -1
        clear_all();
        A[0][0][3] = 1;
        R[0][1] = 1;
        model();
        chk("pin_t2_u", 64'(exp_u), 64'h10);
        chk("pin_t2_v", 64'(exp_v), 64'd0);
        run_job(0);

        // negative noise folds to Q-1
        clear_all();
        E1[0][0] = -1;
        for (int c = 0; c < N; c++) E2[c] = -1;
        model();
        chk("pin_t3_u", 64'(exp_u), 64'h10);
        chk("pin_t3_v", 64'(exp_v), 64'(pack_v(16, 16, 16, 16)));
        run_job(0);

        // abort beats in_valid while idle
        wait_idle();
        in_valid = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        chk("abort_idle_no_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        abort = 1'b0;
        repeat (LAT + 5) @(negedge clk);

        // backpressure
        randomize_job(1'b0);
        run_job(10);

        // random jobs
        for (int k = 0; k < 200; k++) begin
            randomize_job(k % 10 == 0);
            run_job(0);
        end

        // abort in MUL_U
        prev_u = exp_u;
        randomize_job(1'b0);
        drive();
        wait_idle();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (30) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_keeps_u", 64'(u_flat), 64'(prev_u));

        // reset in MUL_V
        wait_idle();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (75) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_u", 64'(u_flat), 64'd0);
        chk("mid_rst_v", 64'(v_flat), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 10) @(negedge clk);

        // out-of-range noise still used, flagged
        randomize_job(1'b0);
        R[1][2] = 2;
        model();
        chk("pin_t6_err", 64'(exp_err), 64'd1);
        run_job(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
